// File: rtl/boot_load_sequencer.sv
// Boot load sequencer: takes a program-length word from the UART word
// receiver, writes that many words into instruction memory, answers the host
// with an acknowledge or error byte, then starts the core and forwards every
// later word to the scan-data FIFO.
module boot_load_sequencer #(
  parameter int unsigned IMEM_DEPTH = 16384,
  parameter int unsigned ADDR_W     = 14,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       rword,
  input  logic              rword_ready,
  input  logic              ferr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              fifo_we,
  output logic [31:0]       fifo_wdata,
  input  logic              fifo_full,
  output logic              tx_req,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  output logic              pc_start,
  output logic              rx_err,
  output logic [ADDR_W:0]   loaded_words
);

  typedef enum logic [2:0] {
    S_WAIT_LEN,
    S_LOAD,
    S_ACK,
    S_ERR,
    S_RUN
  } state_t;

  localparam logic [31:0]     DEPTH32  = 32'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] addr;
  logic              len_ok;

  // A length is usable only if nonzero and no larger than the memory; the
  // full 32-bit compare makes any set upper bit a rejection.
  always_comb begin
    len_ok = (rword != '0) && (rword <= DEPTH32);
  end

  // Boot sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_WAIT_LEN;
      remaining    <= '0;
      len_q        <= '0;
      addr         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      fifo_we      <= 1'b0;
      fifo_wdata   <= '0;
      tx_req       <= 1'b0;
      tx_byte      <= '0;
      pc_start     <= 1'b0;
      rx_err       <= 1'b0;
      loaded_words <= '0;
    end else begin
      imem_we <= 1'b0;
      fifo_we <= 1'b0;
      case (state)
        S_WAIT_LEN: begin
          if (rword_ready) begin
            if (ferr) begin
              rx_err  <= 1'b1;
              tx_req  <= 1'b1;
              tx_byte <= ERR_BYTE;
              state   <= S_ERR;
            end else if (!len_ok) begin
              tx_req  <= 1'b1;
              tx_byte <= ERR_BYTE;
              state   <= S_ERR;
            end else begin
              remaining <= rword[ADDR_W:0];
              len_q     <= rword[ADDR_W:0];
              addr      <= '0;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (rword_ready) begin
            if (ferr) begin
              rx_err  <= 1'b1;
              tx_req  <= 1'b1;
              tx_byte <= ERR_BYTE;
              state   <= S_ERR;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= rword;
              remaining  <= remaining - CNT_ONE;
              // Address is held on the last word so a full-depth load never wraps.
              if (remaining == CNT_ONE) begin
                loaded_words <= len_q;
                tx_req       <= 1'b1;
                tx_byte      <= ACK_BYTE;
                state        <= S_ACK;
              end else begin
                addr <= addr + ADDR_ONE;
              end
            end
          end
        end
        S_ACK, S_ERR: begin
          if (rword_ready) begin
            rx_err <= 1'b1;
          end
          if (!tx_busy) begin
            tx_req <= 1'b0;
            if (state == S_ACK) begin
              pc_start <= 1'b1;
              state    <= S_RUN;
            end else begin
              state <= S_WAIT_LEN;
            end
          end
        end
        S_RUN: begin
          if (rword_ready) begin
            if (ferr || fifo_full) begin
              rx_err <= 1'b1;
            end else begin
              fifo_we    <= 1'b1;
              fifo_wdata <= rword;
            end
          end
        end
        default: state <= S_WAIT_LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Directed bench for boot_load_sequencer, built with a shrunken 8-word
// instruction memory so the full-depth load is short.
module tb_boot_load_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   rword;
  logic          rword_ready;
  logic          ferr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          fifo_we;
  logic [31:0]   fifo_wdata;
  logic          fifo_full;
  logic          tx_req;
  logic [7:0]    tx_byte;
  logic          tx_busy;
  logic          pc_start;
  logic          rx_err;
  logic [AW:0]   loaded_words;

  int n_cmp = 0;
  int n_err = 0;

  boot_load_sequencer #(
    .IMEM_DEPTH(DEPTH),
    .ADDR_W    (AW),
    .ACK_BYTE  (8'hAA),
    .ERR_BYTE  (8'hEE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rword       (rword),
    .rword_ready (rword_ready),
    .ferr        (ferr),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .fifo_we     (fifo_we),
    .fifo_wdata  (fifo_wdata),
    .fifo_full   (fifo_full),
    .tx_req      (tx_req),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .pc_start    (pc_start),
    .rx_err      (rx_err),
    .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  // One-cycle strobe; returns on the following falling edge, where the
  // registered response to the strobe is visible.
  task automatic send_word(input logic [31:0] w, input logic fe);
    @(negedge clk);
    rword       = w;
    ferr        = fe;
    rword_ready = 1'b1;
    @(negedge clk);
    rword_ready = 1'b0;
    ferr        = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    rword_ready = 1'b0;
    ferr        = 1'b0;
    fifo_full   = 1'b0;
    tx_busy     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    if ({imem_we, imem_addr, imem_wdata} !== '0) begin
      $display("FAIL reset_imem: got %b %h %h want all 0", imem_we, imem_addr, imem_wdata); n_err++;
    end
    n_cmp++;
    if ({fifo_we, fifo_wdata} !== '0) begin
      $display("FAIL reset_fifo: got %b %h want all 0", fifo_we, fifo_wdata); n_err++;
    end
    n_cmp++;
    if ({tx_req, tx_byte} !== '0) begin
      $display("FAIL reset_tx: got %b %h want all 0", tx_req, tx_byte); n_err++;
    end
    n_cmp++;
    if ({pc_start, rx_err, loaded_words} !== '0) begin
      $display("FAIL reset_status: got %b %b %h want all 0", pc_start, rx_err, loaded_words); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_bad_len();
    logic [31:0] bad [3];
    bad[0] = 32'd0;
    bad[1] = 32'd9;
    bad[2] = 32'h8000_0001;
    for (int i = 0; i < 3; i++) begin
      send_word(bad[i], 1'b0);
      if (tx_req !== 1'b1 || tx_byte !== 8'hEE) begin
        $display("FAIL badlen%0d_tx: got req=%b byte=%h want 1 ee", i, tx_req, tx_byte); n_err++;
      end
      n_cmp++;
      if (imem_we !== 1'b0) begin
        $display("FAIL badlen%0d_we: got %b want 0", i, imem_we); n_err++;
      end
      n_cmp++;
      @(negedge clk);
      if (tx_req !== 1'b0) begin
        $display("FAIL badlen%0d_txdrop: got %b want 0", i, tx_req); n_err++;
      end
      n_cmp++;
    end
    if (rx_err !== 1'b0 || pc_start !== 1'b0) begin
      $display("FAIL badlen_status: got rx_err=%b pc_start=%b want 0 0", rx_err, pc_start); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_len_one();
    send_word(32'd1, 1'b0);
    send_word(32'hCAFE_0001, 1'b0);
    if (imem_we !== 1'b1 || imem_addr !== 3'd0 || imem_wdata !== 32'hCAFE_0001) begin
      $display("FAIL len1_write: got we=%b addr=%h data=%h want 1 0 cafe0001", imem_we, imem_addr, imem_wdata); n_err++;
    end
    n_cmp++;
    if (tx_req !== 1'b1 || tx_byte !== 8'hAA || loaded_words !== 4'd1) begin
      $display("FAIL len1_ack: got req=%b byte=%h lw=%0d want 1 aa 1", tx_req, tx_byte, loaded_words); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    if (tx_req !== 1'b0 || pc_start !== 1'b1) begin
      $display("FAIL len1_run: got req=%b pc_start=%b want 0 1", tx_req, pc_start); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_ferr_load();
    send_word(32'd4, 1'b0);
    send_word(32'h0000_00A0, 1'b0);
    if (imem_we !== 1'b1 || imem_addr !== 3'd0 || imem_wdata !== 32'h0000_00A0) begin
      $display("FAIL ferr_first: got we=%b addr=%h data=%h want 1 0 a0", imem_we, imem_addr, imem_wdata); n_err++;
    end
    n_cmp++;
    send_word(32'h0000_00B0, 1'b1);
    if (imem_we !== 1'b0 || rx_err !== 1'b1) begin
      $display("FAIL ferr_abort: got we=%b rx_err=%b want 0 1", imem_we, rx_err); n_err++;
    end
    n_cmp++;
    if (tx_req !== 1'b1 || tx_byte !== 8'hEE || pc_start !== 1'b0) begin
      $display("FAIL ferr_tx: got req=%b byte=%h pc=%b want 1 ee 0", tx_req, tx_byte, pc_start); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    if (tx_req !== 1'b0 || pc_start !== 1'b0 || loaded_words !== 4'd0) begin
      $display("FAIL ferr_after: got req=%b pc=%b lw=%0d want 0 0 0", tx_req, pc_start, loaded_words); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_load3();
    logic [31:0] w [3];
    w[0] = 32'h11;
    w[1] = 32'h22;
    w[2] = 32'h33;
    send_word(32'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], 1'b0);
      if (imem_we !== 1'b1 || imem_addr !== 3'(i) || imem_wdata !== w[i]) begin
        $display("FAIL load3_w%0d: got we=%b addr=%h data=%h want 1 %0d %h", i, imem_we, imem_addr, imem_wdata, i, w[i]); n_err++;
      end
      n_cmp++;
    end
    if (tx_req !== 1'b1 || tx_byte !== 8'hAA || loaded_words !== 4'd3 || pc_start !== 1'b0) begin
      $display("FAIL load3_ack: got req=%b byte=%h lw=%0d pc=%b want 1 aa 3 0", tx_req, tx_byte, loaded_words, pc_start); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    if (tx_req !== 1'b0 || pc_start !== 1'b1 || imem_we !== 1'b0) begin
      $display("FAIL load3_run: got req=%b pc=%b we=%b want 0 1 0", tx_req, pc_start, imem_we); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_fifo();
    send_word(32'hDEAD_BEEF, 1'b0);
    if (fifo_we !== 1'b1 || fifo_wdata !== 32'hDEAD_BEEF) begin
      $display("FAIL fifo_w0: got we=%b data=%h want 1 deadbeef", fifo_we, fifo_wdata); n_err++;
    end
    n_cmp++;
    send_word(32'h5, 1'b0);
    if (fifo_we !== 1'b1 || fifo_wdata !== 32'h5) begin
      $display("FAIL fifo_w1: got we=%b data=%h want 1 5", fifo_we, fifo_wdata); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    if (fifo_we !== 1'b0 || rx_err !== 1'b0 || pc_start !== 1'b1) begin
      $display("FAIL fifo_idle: got we=%b rx_err=%b pc=%b want 0 0 1", fifo_we, rx_err, pc_start); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_fifo_full();
    fifo_full = 1'b1;
    send_word(32'h77, 1'b0);
    if (fifo_we !== 1'b0 || rx_err !== 1'b1) begin
      $display("FAIL fifo_full: got we=%b rx_err=%b want 0 1", fifo_we, rx_err); n_err++;
    end
    n_cmp++;
    fifo_full = 1'b0;
  endtask

  task automatic test_busy_full_depth();
    tx_busy = 1'b1;
    send_word(32'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_word(32'h100 + 32'(i), 1'b0);
      if (imem_we !== 1'b1 || imem_addr !== 3'(i) || imem_wdata !== 32'h100 + 32'(i)) begin
        $display("FAIL depth_w%0d: got we=%b addr=%h data=%h want 1 %0d %h", i, imem_we, imem_addr, imem_wdata, i, 32'h100 + i); n_err++;
      end
      n_cmp++;
    end
    if (tx_req !== 1'b1 || loaded_words !== 4'd8) begin
      $display("FAIL depth_ack: got req=%b lw=%0d want 1 8", tx_req, loaded_words); n_err++;
    end
    n_cmp++;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (tx_req !== 1'b1 || pc_start !== 1'b0) begin
        $display("FAIL busy_hold%0d: got req=%b pc=%b want 1 0", k, tx_req, pc_start); n_err++;
      end
      n_cmp++;
      if (k == 3) begin
        rword       = 32'h55;
        rword_ready = 1'b1;
      end
      if (k == 4) begin
        rword_ready = 1'b0;
        if (rx_err !== 1'b1 || imem_we !== 1'b0 || fifo_we !== 1'b0) begin
          $display("FAIL ack_drop: got rx_err=%b we=%b fwe=%b want 1 0 0", rx_err, imem_we, fifo_we); n_err++;
        end
        n_cmp++;
      end
    end
    tx_busy = 1'b0;
    @(negedge clk);
    if (tx_req !== 1'b0 || pc_start !== 1'b1) begin
      $display("FAIL busy_release: got req=%b pc=%b want 0 1", tx_req, pc_start); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_midload();
    send_word(32'd4, 1'b0);
    send_word(32'h1111, 1'b0);
    send_word(32'h2222, 1'b0);
    if (imem_we !== 1'b1 || imem_addr !== 3'd1) begin
      $display("FAIL mid_pre: got we=%b addr=%h want 1 1", imem_we, imem_addr); n_err++;
    end
    n_cmp++;
    #2;
    reset = 1'b0;
    #1;
    if ({imem_we, imem_addr, imem_wdata, fifo_we, fifo_wdata} !== '0) begin
      $display("FAIL mid_async_mem: got %b %h %h %b %h want all 0", imem_we, imem_addr, imem_wdata, fifo_we, fifo_wdata); n_err++;
    end
    n_cmp++;
    if ({tx_req, tx_byte, pc_start, rx_err, loaded_words} !== '0) begin
      $display("FAIL mid_async_status: got %b %h %b %b %h want all 0", tx_req, tx_byte, pc_start, rx_err, loaded_words); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    reset = 1'b1;
    send_word(32'd1, 1'b0);
    send_word(32'h3333, 1'b0);
    if (imem_we !== 1'b1 || imem_addr !== 3'd0 || tx_req !== 1'b1 || tx_byte !== 8'hAA) begin
      $display("FAIL mid_reload: got we=%b addr=%h req=%b byte=%h want 1 0 1 aa", imem_we, imem_addr, tx_req, tx_byte); n_err++;
    end
    n_cmp++;
  endtask

  initial begin
    reset       = 1'b0;
    rword       = '0;
    rword_ready = 1'b0;
    ferr        = 1'b0;
    fifo_full   = 1'b0;
    tx_busy     = 1'b0;
    test_reset();
    test_bad_len();
    test_len_one();
    do_reset();
    test_ferr_load();
    do_reset();
    test_load3();
    test_fifo();
    test_fifo_full();
    do_reset();
    test_busy_full_depth();
    do_reset();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
